mem_arbiter: RTL

Two-port arbiter and sequencer for the 32x16 unified memory of the multicycle processor. It shares the single memory port between the instruction-fetch requester (read-only) and the load/store requester (read/write). It drives the memory's active-low `write`/`read` strobes, which the memory acts on at the falling edge. It returns read data with a one-cycle acknowledge, and uses round-robin arbitration with an optional wait-state count.

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Purpose : round-robin arbiter/sequencer sharing one 32x16 memory port between fetch and load/store.
// Latency : grant on the sampling edge; ack one cycle after ACCESS (1+WAIT_CYCLES cycles); back to IDLE next edge.
// Backpres: requesters hold req until ack; a losing or late request waits in place until IDLE samples it.
//
// Ports:
//   clk, proc_rst      clock and asynchronous active-low reset (shared with the memory)
//   f_req/f_addr       fetch request (read-only); f_ack/f_rdata one-cycle ack with registered data
//   d_req/d_we/d_addr/d_wdata  load/store request; d_ack/d_rdata one-cycle ack, data for loads
//   mem_*              memory port; mem_write/mem_read are active-low strobes the memory acts on at negedge
//   busy               high whenever the sequencer is not idle
//   grant_d            owner of the current/last access (1 = data, 0 = fetch)
module mem_arbiter #(
  parameter int AW          = 5,
  parameter int DW          = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          proc_rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_d
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          write_q, write_d;
  logic          read_q, read_d;
  logic          owner_q, owner_d;
  logic          f_ack_q, f_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] f_rdata_q, f_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          pick_data;

  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b1;
      read_q    <= 1'b1;
      owner_q   <= 1'b1;   // data counts as last owner, so fetch wins the first tie
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      read_q    <= read_d;
      owner_q   <= owner_d;
      f_ack_q   <= f_ack_d;
      d_ack_q   <= d_ack_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    read_d    = read_q;
    owner_d   = owner_q;
    f_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    pick_data = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          // On a tie, data wins only if fetch owned the previous access.
          pick_data = d_req && (!f_req || !owner_q);
          state_d   = ACCESS;
          cnt_d     = WAIT_INIT;
          owner_d   = pick_data;
          addr_d    = pick_data ? d_addr : f_addr;
          wdata_d   = pick_data ? d_wdata : '0;
          write_d   = !(pick_data && d_we);
          read_d    = pick_data && d_we;
        end
      end
      ACCESS: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
          write_d = 1'b1;
          read_d  = 1'b1;
          // mem_rdata was refreshed at the last falling edge of ACCESS.
          if (!read_q) begin
            if (owner_q) d_rdata_d = mem_rdata;
            else         f_rdata_d = mem_rdata;
          end
          if (owner_q) d_ack_d = 1'b1;
          else         f_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign f_ack     = f_ack_q;
  assign d_ack     = d_ack_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_write = write_q;
  assign mem_read  = read_q;
  assign busy      = (state_q != IDLE);
  assign grant_d   = owner_q;

endmodule
